mult_sequencer: RTL and testbench
=================================

Name: mult_sequencer

Overview:
- Control stage directly upstream of the radix-4 Booth multiply datapath.
- Accepts a multiply request with two 32-bit operands, latches them, and drives the datapath's start/operand inputs.
- Counts the Booth iterations, then captures the datapath's product and overflow flag.
- Presents the result to the processor writeback path with a one-cycle ready pulse and a busy/stall indication.

Parameters:
- WIDTH, 32, operand and result width in bits.
- ITERS, 16, Booth iterations per multiply (WIDTH/2, radix-4).
- CW, 5, width of the iteration counter; must satisfy 2^CW > ITERS.

Ports:
- clk  in  1  rising-edge clock; single clock domain.
- clr_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- ctrl_mult  in  1  request; sampled high on an edge = start a multiply.
- operand_a  in  WIDTH  multiplier; sampled on the accept edge.
- operand_b  in  WIDTH  multiplicand; sampled on the accept edge.
- mult_start  out  1  to datapath: load initial Booth register this cycle.
- mult_multiplier  out  WIDTH  to datapath: latched operand_a, held stable for the whole run.
- mult_multiplicand  out  WIDTH  to datapath: latched operand_b, held stable for the whole run.
- mult_out  in  WIDTH  from datapath: current product low word (combinational).
- mult_ovf  in  1  from datapath: current overflow flag (combinational).
- result  out  WIDTH  captured product.
- result_exc  out  1  captured overflow flag.
- result_rdy  out  1  one-cycle pulse: result and result_exc are valid.
- busy  out  1  high in LOAD and RUN; processor stalls on it.

Behaviour:
- Reset (clr_n=0 at an edge):
  - State goes to IDLE; count=0.
  - Operand latches, result and result_exc cleared to 0.
  - mult_start, result_rdy and busy are 0.
  - Reset wins over every other input, including a simultaneous ctrl_mult.
  - Reset mid-run aborts the operation with no result_rdy.
- States: IDLE, LOAD, RUN, DONE (registered; outputs decoded from state).
- IDLE: busy=0. ctrl_mult=1 at an edge latches operand_a/operand_b and goes to LOAD.
- LOAD: lasts exactly one cycle.
  - mult_start=1, busy=1.
  - Next edge: count=0, go to RUN.
- RUN: busy=1, mult_start=0.
  - Each edge increments count.
  - On the edge where count==ITERS-1: capture mult_out into result and mult_ovf into result_exc, go to DONE.
- DONE: lasts one cycle.
  - result_rdy=1, busy=0.
  - Next edge: go to IDLE, or to LOAD if ctrl_mult=1 (back-to-back accept).
- Latency: accept edge E0; result_rdy is high in the cycle after edge E0+ITERS+1 (17 cycles for the defaults).
- Restart: ctrl_mult=1 at any edge in LOAD or RUN aborts the current operation.
  - Re-latches operands and goes to LOAD; count is reset.
  - No result_rdy is produced for the aborted operation.
- Hold rules:
  - result and result_exc hold their last captured value until the next capture or reset.
  - mult_multiplier/mult_multiplicand change only on accept edges. The datapath reloads its multiplicand register every cycle, so these must stay stable.
- Arithmetic: the sequencer does no arithmetic. Signed two's-complement semantics are defined by the datapath; the sequencer transfers mult_out/mult_ovf unmodified.
- Counter never wraps: it exits RUN at ITERS-1. CW must cover ITERS.
- ctrl_mult held high continuously: it is treated as a new request on every eligible edge (LOAD/RUN restart). Callers must therefore pulse it for exactly one cycle.

Test Plan:
- Basic multiply: reset, then pulse ctrl_mult with a=7, b=6, driving the datapath model.
  - Expect mult_start high exactly one cycle and busy high for 17 cycles.
  - Expect result_rdy high for exactly one cycle with result=42, result_exc=0.
- Signed and boundary products, one per run:
  - a=-3, b=5 -> result=0xFFFFFFF1, exc=0.
  - a=0x7FFFFFFF, b=-1 -> result=0x80000001, exc=0.
  - a=0x00010000, b=0x00010000 -> result=0, exc=1.
- Back-to-back: assert ctrl_mult (a=2, b=3) in the DONE cycle of the previous op.
  - Expect the previous result valid in that cycle, LOAD on the next cycle, then result=6 after 17 more cycles.
  - Expect no idle gap.
- Restart mid-run: start a=100, b=100; at RUN count=5, pulse ctrl_mult with a=4, b=4.
  - Expect exactly one result_rdy, with result=16.
  - Expect it 17 cycles after the second pulse.
- Reset mid-run: start a=9, b=9; drive clr_n=0 at RUN count=8.
  - Expect busy=0, result=0, result_rdy never asserted.
  - A following multiply a=3, b=3 returns 9.
- Operand stability: change operand_a/operand_b every cycle during RUN.
  - Expect mult_multiplier/mult_multiplicand constant and the result equal to the originally latched product.

Source files
------------

// File: rtl/mult_sequencer.sv
// Control sequencer for the radix-4 Booth multiply datapath: latches operands, counts iterations,
// captures the product and overflow flag, and signals the writeback path.
module mult_sequencer #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned ITERS = 16,
  parameter int unsigned CW    = 5
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             ctrl_mult,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             mult_start,
  output logic [WIDTH-1:0] mult_multiplier,
  output logic [WIDTH-1:0] mult_multiplicand,
  input  logic [WIDTH-1:0] mult_out,
  input  logic             mult_ovf,
  output logic [WIDTH-1:0] result,
  output logic             result_exc,
  output logic             result_rdy,
  output logic             busy
);

  localparam logic [CW-1:0] LastIter = CW'(ITERS - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             exc_q, exc_d;
  logic             start_q, start_d;
  logic             busy_q, busy_d;
  logic             rdy_q, rdy_d;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    exc_d   = exc_q;

    // A request in any state but IDLE also aborts whatever is in flight.
    if (ctrl_mult) begin
      state_d = StLoad;
      count_d = '0;
      a_d     = operand_a;
      b_d     = operand_b;
    end else begin
      unique case (state_q)
        StIdle: state_d = StIdle;
        StLoad: begin
          state_d = StRun;
          count_d = '0;
        end
        StRun: begin
          count_d = count_q + CW'(1);
          if (count_q == LastIter) begin
            state_d = StDone;
            res_d   = mult_out;
            exc_d   = mult_ovf;
          end
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end

    // Outputs are registered from the next state so they line up with state_q.
    start_d = (state_d == StLoad);
    busy_d  = (state_d == StLoad) || (state_d == StRun);
    rdy_d   = (state_d == StDone);
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state_q <= StIdle;
      count_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      exc_q   <= 1'b0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      exc_q   <= exc_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      rdy_q   <= rdy_d;
    end
  end

  assign mult_start        = start_q;
  assign mult_multiplier   = a_q;
  assign mult_multiplicand = b_q;
  assign result            = res_q;
  assign result_exc        = exc_q;
  assign result_rdy        = rdy_q;
  assign busy              = busy_q;

endmodule

// File: tb/tb_mult_sequencer.sv
// Bench for mult_sequencer: a cycle-counting Booth datapath model plus a result scoreboard.
module tb_mult_sequencer;

  localparam int unsigned W     = 32;
  localparam int unsigned ITERS = 16;
  localparam int          LAT   = 17;

  logic         clk = 1'b0;
  logic         clr_n;
  logic         ctrl_mult;
  logic [W-1:0] operand_a;
  logic [W-1:0] operand_b;
  logic         mult_start;
  logic [W-1:0] mult_multiplier;
  logic [W-1:0] mult_multiplicand;
  logic [W-1:0] mult_out;
  logic         mult_ovf;
  logic [W-1:0] result;
  logic         result_exc;
  logic         result_rdy;
  logic         busy;

  int checks = 0;
  int errors = 0;
  logic [W:0] exp_q[$];
  int dp_cnt = 255;

  always #5 clk = ~clk;

  mult_sequencer #(.WIDTH(W), .ITERS(ITERS), .CW(5)) dut (
    .clk              (clk),
    .clr_n            (clr_n),
    .ctrl_mult        (ctrl_mult),
    .operand_a        (operand_a),
    .operand_b        (operand_b),
    .mult_start       (mult_start),
    .mult_multiplier  (mult_multiplier),
    .mult_multiplicand(mult_multiplicand),
    .mult_out         (mult_out),
    .mult_ovf         (mult_ovf),
    .result           (result),
    .result_exc       (result_exc),
    .result_rdy       (result_rdy),
    .busy             (busy)
  );

  function automatic logic [W:0] prod_of(input logic [W-1:0] a, input logic [W-1:0] b);
    longint p;
    logic   ovf;
    p   = longint'(signed'(a)) * longint'(signed'(b));
    ovf = (p != longint'(signed'(p[31:0])));
    return {ovf, p[31:0]};
  endfunction

  // Datapath model: the final product only appears in the last iteration cycle.
  always @(posedge clk) begin
    if (mult_start === 1'b1) dp_cnt <= 0;
    else if (dp_cnt < 255) dp_cnt <= dp_cnt + 1;
  end

  always_comb begin
    logic [W:0] p;
    p = prod_of(mult_multiplier, mult_multiplicand);
    if (dp_cnt == int'(ITERS) - 1) begin
      mult_out = p[W-1:0];
      mult_ovf = p[W];
    end else begin
      mult_out = p[W-1:0] ^ 32'hA5A5_5A5A;
      mult_ovf = ~p[W];
    end
  end

  always @(negedge clk) begin
    logic [W:0] e;
    if (result_rdy === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rdy: got result=%h exc=%b, required no result_rdy",
                 result, result_exc);
      end else begin
        e = exp_q.pop_front();
        if ({result_exc, result} !== e) begin
          errors++;
          $display("FAIL scoreboard: got exc=%b result=%h, required exc=%b result=%h",
                   result_exc, result, e[W], e[W-1:0]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs from the cycle after an accept edge until result_rdy or a cycle budget expires.
  task automatic wait_rdy(output int cyc, output int starts, output int busys);
    cyc = 0; starts = 0; busys = 0;
    while (result_rdy !== 1'b1 && cyc < 40) begin
      if (mult_start === 1'b1) starts++;
      if (busy === 1'b1) busys++;
      step();
      cyc++;
    end
  endtask

  task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b);
    ctrl_mult = 1'b1; operand_a = a; operand_b = b;
    step();
    ctrl_mult = 1'b0;
  endtask

  task automatic run_mult(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W:0] e);
    int cyc, starts, busys;
    exp_q.push_back(e);
    accept(a, b);
    checks++;
    if (mult_start !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL %s_load: got start=%b busy=%b, required 1 1", nm, mult_start, busy);
    end
    wait_rdy(cyc, starts, busys);
    checks++;
    if (cyc != LAT || starts != 1 || busys != LAT || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_timing: got lat=%0d starts=%0d busy_cycles=%0d busy=%b, required %0d 1 %0d 0",
               nm, cyc, starts, busys, busy, LAT, LAT);
    end
    step();
    checks++;
    if (result_rdy !== 1'b0 || busy !== 1'b0 || {result_exc, result} !== e) begin
      errors++;
      $display("FAIL %s_hold: got rdy=%b busy=%b exc=%b result=%h, required 0 0 %b %h",
               nm, result_rdy, busy, result_exc, result, e[W], e[W-1:0]);
    end
  endtask

  task automatic test_reset();
    clr_n = 1'b0; ctrl_mult = 1'b1; operand_a = 32'hDEAD_BEEF; operand_b = 32'h1234_5678;
    step(); step();
    checks++;
    if (busy !== 1'b0 || mult_start !== 1'b0 || result_rdy !== 1'b0 || result !== '0 ||
        result_exc !== 1'b0 || mult_multiplier !== '0 || mult_multiplicand !== '0) begin
      errors++;
      $display("FAIL reset: got busy=%b start=%b rdy=%b res=%h exc=%b a=%h b=%h, required all 0",
               busy, mult_start, result_rdy, result, result_exc, mult_multiplier,
               mult_multiplicand);
    end
    ctrl_mult = 1'b0; clr_n = 1'b1;
    step();
  endtask

  task automatic test_signed();
    run_mult("basic", 32'd7, 32'd6, {1'b0, 32'd42});
    run_mult("neg", 32'hFFFF_FFFD, 32'd5, {1'b0, 32'hFFFF_FFF1});
    run_mult("maxneg", 32'h7FFF_FFFF, 32'hFFFF_FFFF, {1'b0, 32'h8000_0001});
    run_mult("ovf", 32'h0001_0000, 32'h0001_0000, {1'b1, 32'h0000_0000});
  endtask

  task automatic test_back_to_back();
    int cyc, starts, busys;
    exp_q.push_back({1'b0, 32'd25});
    accept(32'd5, 32'd5);
    wait_rdy(cyc, starts, busys);
    checks++;
    if (cyc != LAT) begin
      errors++;
      $display("FAIL b2b_first_lat: got %0d, required %0d", cyc, LAT);
    end
    exp_q.push_back({1'b0, 32'd6});
    accept(32'd2, 32'd3);
    checks++;
    if (mult_start !== 1'b1 || busy !== 1'b1 || mult_multiplier !== 32'd2) begin
      errors++;
      $display("FAIL b2b_gap: got start=%b busy=%b a=%h, required 1 1 2",
               mult_start, busy, mult_multiplier);
    end
    wait_rdy(cyc, starts, busys);
    checks++;
    if (cyc != LAT || busys != LAT) begin
      errors++;
      $display("FAIL b2b_second: got lat=%0d busy_cycles=%0d, required %0d %0d", cyc, busys,
               LAT, LAT);
    end
    step();
  endtask

  task automatic test_restart();
    int cyc, starts, busys;
    accept(32'd100, 32'd100);
    repeat (6) step();
    exp_q.push_back({1'b0, 32'd16});
    accept(32'd4, 32'd4);
    wait_rdy(cyc, starts, busys);
    checks++;
    if (cyc != LAT || starts != 1) begin
      errors++;
      $display("FAIL restart: got lat=%0d starts=%0d, required %0d 1", cyc, starts, LAT);
    end
    repeat (20) step();
  endtask

  task automatic test_reset_midrun();
    accept(32'd9, 32'd9);
    repeat (9) step();
    clr_n = 1'b0;
    step();
    checks++;
    if (busy !== 1'b0 || result !== '0 || result_rdy !== 1'b0) begin
      errors++;
      $display("FAIL reset_midrun: got busy=%b result=%h rdy=%b, required 0 0 0",
               busy, result, result_rdy);
    end
    clr_n = 1'b1;
    repeat (20) step();
    run_mult("after_reset", 32'd3, 32'd3, {1'b0, 32'd9});
  endtask

  task automatic test_operand_stability();
    int cyc = 0;
    logic [W-1:0] a = 32'h0000_1234;
    logic [W-1:0] b = 32'hFFFF_FFB3;
    exp_q.push_back(prod_of(a, b));
    accept(a, b);
    while (result_rdy !== 1'b1 && cyc < 40) begin
      operand_a = $urandom;
      operand_b = $urandom;
      checks++;
      if (mult_multiplier !== a || mult_multiplicand !== b) begin
        errors++;
        $display("FAIL stability: got a=%h b=%h, required %h %h", mult_multiplier,
                 mult_multiplicand, a, b);
      end
      step();
      cyc++;
    end
    checks++;
    if (cyc != LAT) begin
      errors++;
      $display("FAIL stability_lat: got %0d, required %0d", cyc, LAT);
    end
    step();
  endtask

  initial begin
    clr_n = 1'b0; ctrl_mult = 1'b0; operand_a = '0; operand_b = '0;
    test_reset();
    test_signed();
    test_back_to_back();
    test_restart();
    test_reset_midrun();
    test_operand_stability();
    repeat (3) step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_results: got %0d outstanding, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
